// File: rtl/camerametnios_nios2_mul_seq_unit.sv
// ---------------------------------------------------------------------------
// camerametnios_nios2_mul_seq_unit
//
// Sequential signed/unsigned multiplier for the camerametnios Nios II
// datapath. Produces the full 2*DATA_W product of two DATA_W operands by
// reusing a single SLICE_W x SLICE_W multiplier, one partial product per
// clock, on sign-stripped magnitudes. The sign is re-applied in one
// correction cycle at the end.
//
// Optional build macro: MUL_SEQ_EARLY_OUT_EN
//   When defined, only the slices up to the highest non-zero slice of each
//   magnitude are multiplied, which shortens latency for small operands.
//   Results are identical with or without the macro.
//
// Ports:
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous active-high reset
//   in_valid     in   1       operands and sign modes valid
//   in_ready     out  1       unit idle and able to accept an operation
//   in_a/in_b    in   DATA_W  operands
//   in_a_signed  in   1       1: in_a is two's complement
//   in_b_signed  in   1       1: in_b is two's complement
//   out_valid    out  1       result valid, held until out_ready
//   out_ready    in   1       consumer accepts result
//   out_lo       out  DATA_W  product bits [DATA_W-1:0]
//   out_hi       out  DATA_W  product bits [2*DATA_W-1:DATA_W]
//   busy         out  1       operation in progress (not IDLE)
// ---------------------------------------------------------------------------
module camerametnios_nios2_mul_seq_unit #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_a_signed,
    input  logic              in_b_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_lo,
    output logic [DATA_W-1:0] out_hi,
    output logic              busy
);

    localparam int N     = DATA_W / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SH_W  = $clog2(2 * DATA_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [DATA_W-1:0]     r_mag_a;
    logic [DATA_W-1:0]     r_mag_b;
    logic                  r_neg;
    logic [2*DATA_W-1:0]   r_acc;
    logic [IDX_W-1:0]      r_i;
    logic [IDX_W-1:0]      r_j;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;
    logic [DATA_W-1:0]     r_out_lo;
    logic [DATA_W-1:0]     r_out_hi;

    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_W-1:0]     w_mag_a;
    logic [DATA_W-1:0]     w_mag_b;
    logic [SLICE_W-1:0]    w_slice_a;
    logic [SLICE_W-1:0]    w_slice_b;
    logic [2*SLICE_W-1:0]  w_prod;
    logic [SH_W-1:0]       w_shift;
    logic [2*DATA_W-1:0]   w_pp;
    logic [2*DATA_W-1:0]   w_acc_neg;
    logic [IDX_W-1:0]      w_ka;
    logic [IDX_W-1:0]      w_kb;

    // Operand magnitudes: a signed operand with its MSB set is negated.
    // -2^(DATA_W-1) wraps to 2^(DATA_W-1), which is the correct unsigned magnitude.
    assign w_a_neg = in_a_signed & in_a[DATA_W-1];
    assign w_b_neg = in_b_signed & in_b[DATA_W-1];
    assign w_mag_a = w_a_neg ? (~in_a + {{(DATA_W-1){1'b0}}, 1'b1}) : in_a;
    assign w_mag_b = w_b_neg ? (~in_b + {{(DATA_W-1){1'b0}}, 1'b1}) : in_b;

    // Single shared slice multiplier and its weighted placement in the accumulator.
    assign w_slice_a = r_mag_a[r_i*SLICE_W +: SLICE_W];
    assign w_slice_b = r_mag_b[r_j*SLICE_W +: SLICE_W];
    assign w_prod    = w_slice_a * w_slice_b;
    assign w_shift   = SH_W'((32'(r_i) + 32'(r_j)) * 32'(SLICE_W));
    assign w_pp      = (2*DATA_W)'(w_prod) << w_shift;
    assign w_acc_neg = ~r_acc + {{(2*DATA_W-1){1'b0}}, 1'b1};

`ifdef MUL_SEQ_EARLY_OUT_EN
    logic [IDX_W-1:0] r_ka;
    logic [IDX_W-1:0] r_kb;

    // Index of the highest non-zero slice of a magnitude (0 for a zero operand).
    function automatic logic [IDX_W-1:0] top_slice(input logic [DATA_W-1:0] v);
        logic [IDX_W-1:0] k;
        k = {IDX_W{1'b0}};
        for (int s = 0; s < N; s++) begin
            if (v[s*SLICE_W +: SLICE_W] != {SLICE_W{1'b0}}) begin
                k = IDX_W'(s);
            end else begin
                k = k;
            end
        end
        return k;
    endfunction

    assign w_ka = r_ka;
    assign w_kb = r_kb;

    // Per-operation loop limits captured at accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ka <= {IDX_W{1'b0}};
            r_kb <= {IDX_W{1'b0}};
        end else if (r_state == ST_IDLE && in_valid && r_in_ready) begin
            r_ka <= top_slice(w_mag_a);
            r_kb <= top_slice(w_mag_b);
        end else begin
            r_ka <= r_ka;
            r_kb <= r_kb;
        end
    end
`else
    assign w_ka = IDX_W'(N - 1);
    assign w_kb = IDX_W'(N - 1);
`endif

    // Control FSM, accumulator datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mag_a     <= {DATA_W{1'b0}};
            r_mag_b     <= {DATA_W{1'b0}};
            r_neg       <= 1'b0;
            r_acc       <= {(2*DATA_W){1'b0}};
            r_i         <= {IDX_W{1'b0}};
            r_j         <= {IDX_W{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_lo    <= {DATA_W{1'b0}};
            r_out_hi    <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_mag_a    <= w_mag_a;
                        r_mag_b    <= w_mag_b;
                        r_neg      <= w_a_neg ^ w_b_neg;
                        r_acc      <= {(2*DATA_W){1'b0}};
                        r_i        <= {IDX_W{1'b0}};
                        r_j        <= {IDX_W{1'b0}};
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_MUL;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                ST_MUL: begin
                    // j is the inner loop index, i the outer.
                    r_acc <= r_acc + w_pp;
                    if (r_j == w_kb) begin
                        r_j <= {IDX_W{1'b0}};
                        if (r_i == w_ka) begin
                            r_state <= ST_FIX;
                        end else begin
                            r_i <= r_i + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        r_j <= r_j + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_FIX: begin
                    // A zero magnitude negates to zero, so -0 needs no special case.
                    if (r_neg) begin
                        r_acc    <= w_acc_neg;
                        r_out_lo <= w_acc_neg[DATA_W-1:0];
                        r_out_hi <= w_acc_neg[2*DATA_W-1:DATA_W];
                    end else begin
                        r_out_lo <= r_acc[DATA_W-1:0];
                        r_out_hi <= r_acc[2*DATA_W-1:DATA_W];
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    // First DONE cycle raises out_valid; it then holds until taken.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_lo    = r_out_lo;
    assign out_hi    = r_out_hi;

endmodule
